// File: rtl/pvt_meas_sequencer.sv
// Sequencer for the clk-to-q + setup delay-chain macro: runs 2^n measurements per
// request, accumulates sum/min/max/invalid count and returns the averaged result.
module pvt_meas_sequencer #(
  parameter int CNT_WIDTH   = 8,
  parameter int MAX_LOG2    = 4,
  parameter int WAIT_CYCLES = 64,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_log2,
  input  logic                 abort,
  output logic                 meas_start,
  input  logic [CNT_WIDTH-1:0] meas_cnt,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CNT_WIDTH-1:0] rsp_avg,
  output logic [CNT_WIDTH-1:0] rsp_min,
  output logic [CNT_WIDTH-1:0] rsp_max,
  output logic [MAX_LOG2:0]    rsp_zero_cnt,
  output logic                 busy
);

  localparam int SW = CNT_WIDTH + MAX_LOG2;
  localparam int RW = MAX_LOG2 + 1;
  localparam int TW = $clog2(WAIT_CYCLES + GAP_CYCLES + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(WAIT_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
  localparam logic [2:0]    LOG2_MAX  = 3'(MAX_LOG2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_SAMPLE,
    S_GAP,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [2:0]           r_n;
  logic [RW-1:0]        r_k_last;
  logic [RW-1:0]        r_run_idx;
  logic [TW-1:0]        r_timer;
  logic [SW-1:0]        r_sum;
  logic [CNT_WIDTH-1:0] r_min;
  logic [CNT_WIDTH-1:0] r_max;
  logic [RW-1:0]        r_zero;
  logic [CNT_WIDTH-1:0] r_rsp_avg;
  logic [CNT_WIDTH-1:0] r_rsp_min;
  logic [CNT_WIDTH-1:0] r_rsp_max;
  logic [RW-1:0]        r_rsp_zero;

  logic                 w_abort;
  logic [2:0]           w_n_clamp;
  logic [RW-1:0]        w_k_last;
  logic                 w_last_run;
  logic                 w_sample_zero;
  logic [SW-1:0]        w_sum_nxt;
  logic [CNT_WIDTH-1:0] w_min_nxt;
  logic [CNT_WIDTH-1:0] w_max_nxt;
  logic [RW-1:0]        w_zero_nxt;
  logic                 w_all_zero;

  assign w_abort       = abort && (r_state != S_IDLE);
  assign w_n_clamp     = (req_log2 > LOG2_MAX) ? LOG2_MAX : req_log2;
  assign w_k_last      = RW'((32'd1 << w_n_clamp) - 32'd1);
  assign w_last_run    = (r_run_idx == r_k_last);
  assign w_sample_zero = (meas_cnt == '0);
  assign w_sum_nxt     = r_sum + SW'(meas_cnt);
  assign w_min_nxt     = (!w_sample_zero && (meas_cnt < r_min)) ? meas_cnt : r_min;
  assign w_max_nxt     = (!w_sample_zero && (meas_cnt > r_max)) ? meas_cnt : r_max;
  assign w_zero_nxt    = r_zero + RW'(w_sample_zero);
  // All runs invalid is the only case where min stays at its all-ones seed without
  // a real sample of that value, so it is detected by count rather than by value.
  assign w_all_zero    = (w_zero_nxt == (r_k_last + RW'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (req_valid) w_state_nxt = S_START;
        S_START:  w_state_nxt = S_WAIT;
        S_WAIT:   if (r_timer == WAIT_LAST) w_state_nxt = S_SAMPLE;
        S_SAMPLE: w_state_nxt = w_last_run ? S_DONE : S_GAP;
        S_GAP:    if (r_timer == GAP_LAST) w_state_nxt = S_START;
        S_DONE:   if (rsp_ready) w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n        <= '0;
      r_k_last   <= '0;
      r_run_idx  <= '0;
      r_timer    <= '0;
      r_sum      <= '0;
      r_min      <= '1;
      r_max      <= '0;
      r_zero     <= '0;
      r_rsp_avg  <= '0;
      r_rsp_min  <= '0;
      r_rsp_max  <= '0;
      r_rsp_zero <= '0;
    end else if (w_abort) begin
      r_run_idx  <= '0;
      r_timer    <= '0;
      r_sum      <= '0;
      r_min      <= '1;
      r_max      <= '0;
      r_zero     <= '0;
      r_rsp_avg  <= '0;
      r_rsp_min  <= '0;
      r_rsp_max  <= '0;
      r_rsp_zero <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_n        <= w_n_clamp;
            r_k_last   <= w_k_last;
            r_run_idx  <= '0;
            r_timer    <= '0;
            r_sum      <= '0;
            r_min      <= '1;
            r_max      <= '0;
            r_zero     <= '0;
            r_rsp_avg  <= '0;
            r_rsp_min  <= '0;
            r_rsp_max  <= '0;
            r_rsp_zero <= '0;
          end
        end
        S_START: r_timer <= '0;
        S_WAIT:  r_timer <= r_timer + TW'(1);
        S_SAMPLE: begin
          r_sum   <= w_sum_nxt;
          r_min   <= w_min_nxt;
          r_max   <= w_max_nxt;
          r_zero  <= w_zero_nxt;
          r_timer <= '0;
          if (w_last_run) begin
            r_rsp_avg  <= CNT_WIDTH'(w_sum_nxt >> r_n);
            r_rsp_min  <= w_all_zero ? '0 : w_min_nxt;
            r_rsp_max  <= w_max_nxt;
            r_rsp_zero <= w_zero_nxt;
          end else begin
            r_run_idx <= r_run_idx + RW'(1);
          end
        end
        S_GAP:   r_timer <= r_timer + TW'(1);
        default: ;
      endcase
    end
  end

  assign req_ready    = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign meas_start   = (r_state == S_START);
  assign rsp_valid    = (r_state == S_DONE);
  assign rsp_avg      = r_rsp_avg;
  assign rsp_min      = r_rsp_min;
  assign rsp_max      = r_rsp_max;
  assign rsp_zero_cnt = r_rsp_zero;

endmodule

// File: tb/tb_pvt_meas_sequencer.sv
// Scoreboard bench for pvt_meas_sequencer: directed requests push expected results,
// a negedge monitor checks start-pulse timing, response values/timing and stability.
module tb_pvt_meas_sequencer;

  localparam int CW  = 8;
  localparam int ML  = 4;
  localparam int WC  = 64;
  localparam int GC  = 4;
  localparam int PER = WC + 2 + GC;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_log2 = '0;
  logic          abort = 1'b0;
  logic          meas_start;
  logic [CW-1:0] meas_cnt = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [CW-1:0] rsp_avg;
  logic [CW-1:0] rsp_min;
  logic [CW-1:0] rsp_max;
  logic [ML:0]   rsp_zero_cnt;
  logic          busy;

  pvt_meas_sequencer #(
    .CNT_WIDTH(CW), .MAX_LOG2(ML), .WAIT_CYCLES(WC), .GAP_CYCLES(GC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_log2(req_log2), .abort(abort), .meas_start(meas_start), .meas_cnt(meas_cnt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_avg(rsp_avg), .rsp_min(rsp_min),
    .rsp_max(rsp_max), .rsp_zero_cnt(rsp_zero_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int avg;
    int mn;
    int mx;
    int zc;
    int k;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   gcyc = 0;
  int   acc_cyc = 0;
  int   pidx = 0;
  int   n_rsp = 0;
  int   pulses_total = 0;
  int   stub[16];
  logic prev_vld = 1'b0;
  int   h_avg, h_min, h_max, h_zc;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, expv);
    end
  endtask

  // Monitor: everything is sampled on the falling edge, inputs move at posedge+2.
  initial begin
    forever begin
      @(negedge clk);
      gcyc++;
      if (meas_start) begin
        chk("start_cycle", gcyc, acc_cyc + 1 + pidx * PER);
        meas_cnt = CW'(stub[pidx & 15]);
        pidx++;
        pulses_total++;
      end
      if (rsp_valid && !prev_vld) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", int'(rsp_valid), 0);
        end else begin
          e = q.pop_front();
          chk("rsp_avg", int'(rsp_avg), e.avg);
          chk("rsp_min", int'(rsp_min), e.mn);
          chk("rsp_max", int'(rsp_max), e.mx);
          chk("rsp_zero_cnt", int'(rsp_zero_cnt), e.zc);
          chk("rsp_cycle", gcyc, acc_cyc + 1 + (e.k - 1) * PER + WC + 2);
          chk("pulse_count", pidx, e.k);
        end
        h_avg = int'(rsp_avg);
        h_min = int'(rsp_min);
        h_max = int'(rsp_max);
        h_zc  = int'(rsp_zero_cnt);
        n_rsp++;
      end else if (rsp_valid) begin
        chk("hold_avg", int'(rsp_avg), h_avg);
        chk("hold_min", int'(rsp_min), h_min);
        chk("hold_max", int'(rsp_max), h_max);
        chk("hold_zc", int'(rsp_zero_cnt), h_zc);
      end
      prev_vld = rsp_valid;
      if (req_valid && req_ready) begin
        acc_cyc = gcyc;
        pidx = 0;
      end
    end
  end

  task automatic set4(input int a, input int b, input int c, input int d);
    stub[0] = a;
    stub[1] = b;
    stub[2] = c;
    stub[3] = d;
  endtask

  task automatic issue(input int l2, input int k, input int avg, input int mn,
                       input int mx, input int zc, input bit expect_rsp);
    exp_t x;
    int guard;
    @(posedge clk); #2;
    guard = 0;
    while (!req_ready && guard < 500) begin
      @(posedge clk); #2;
      guard++;
    end
    if (!req_ready) chk("req_ready_timeout", int'(req_ready), 1);
    if (expect_rsp) begin
      x.avg = avg; x.mn = mn; x.mx = mx; x.zc = zc; x.k = k;
      q.push_back(x);
    end
    req_valid = 1'b1;
    req_log2  = 3'(l2);
    @(posedge clk); #2;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int guard;
    guard = 0;
    while (n_rsp < target && guard < 3000) begin
      @(posedge clk); #2;
      guard++;
    end
    if (n_rsp < target) chk("rsp_timeout", n_rsp, target);
  endtask

  initial begin
    int p0;
    int r0;
    int guard;
    for (int i = 0; i < 16; i++) stub[i] = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_meas_start", int'(meas_start), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_avg", int'(rsp_avg), 0);
    chk("rst_min", int'(rsp_min), 0);
    chk("rst_max", int'(rsp_max), 0);
    chk("rst_zc", int'(rsp_zero_cnt), 0);
    rst_n = 1'b1;

    // Single run and a four-run average.
    set4(14, 0, 0, 0);
    issue(0, 1, 14, 14, 14, 0, 1'b1);
    wait_rsp(1);
    set4(10, 12, 13, 15);
    issue(2, 4, 12, 10, 15, 0, 1'b1);
    wait_rsp(2);

    // Invalid (zero) samples excluded from min/max but included in the sum.
    set4(0, 20, 0, 22);
    issue(2, 4, 10, 20, 22, 2, 1'b1);
    wait_rsp(3);
    set4(0, 0, 0, 0);
    issue(2, 4, 0, 0, 0, 4, 1'b1);
    wait_rsp(4);

    // Clamped run count with response back-pressure.
    for (int i = 0; i < 16; i++) stub[i] = i + 1;
    rsp_ready = 1'b0;
    issue(7, 16, 8, 1, 16, 0, 1'b1);
    wait_rsp(5);
    for (int i = 0; i < 10; i++) begin
      chk("bp_busy", int'(busy), 1);
      chk("bp_req_ready", int'(req_ready), 0);
      chk("bp_rsp_valid", int'(rsp_valid), 1);
      @(posedge clk); #2;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #2;
    chk("hs_rsp_valid", int'(rsp_valid), 0);
    chk("hs_req_ready", int'(req_ready), 1);

    // Abort during WAIT of the third run.
    set4(5, 5, 5, 5);
    issue(2, 4, 0, 0, 0, 0, 1'b0);
    guard = 0;
    while (pidx < 3 && guard < 1000) begin
      @(posedge clk); #2;
      guard++;
    end
    chk("abort_reach_run2", pidx, 3);
    @(posedge clk); #2;
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_req_ready", int'(req_ready), 1);
    chk("abort_rsp_valid", int'(rsp_valid), 0);
    p0 = pulses_total;
    r0 = n_rsp;
    repeat (300) @(posedge clk);
    #2;
    chk("abort_no_pulse", pulses_total, p0);
    chk("abort_no_rsp", n_rsp, r0);
    set4(7, 0, 0, 0);
    issue(0, 1, 7, 7, 7, 0, 1'b1);
    wait_rsp(6);

    // Asynchronous reset while the start pulse is on the macro.
    issue(1, 2, 0, 0, 0, 0, 1'b0);
    chk("pre_rst_meas_start", int'(meas_start), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_meas_start", int'(meas_start), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_rsp_valid", int'(rsp_valid), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("post_rst_req_ready", int'(req_ready), 1);
    chk("post_rst_busy", int'(busy), 0);

    // Full-scale sample: min equals the all-ones seed value.
    set4(255, 0, 0, 0);
    issue(0, 1, 255, 255, 255, 0, 1'b1);
    wait_rsp(7);
    repeat (5) @(posedge clk);
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pvt_meas_sequencer.md
Name: pvt_meas_sequencer

Overview:
- Controller that sequences the clk-to-q + setup delay-chain measurement macro over repeated runs.
- Per request: issues 2^n single-cycle start pulses, waits a fixed settle window after each, samples the macro's count, accumulates sum/min/max/invalid count, returns averaged result via valid/ready response.
- Sits between the PVT monitor register/host interface and the measurement macro; sole driver of the macro's start input.

Parameters:
CNT_WIDTH, 8, width of the macro's measured count and of avg/min/max outputs
MAX_LOG2, 4, maximum log2 of runs per request (max 16 runs)
WAIT_CYCLES, 64, cycles spent in WAIT after each start pulse (>=1)
GAP_CYCLES, 4, idle cycles between runs (>=1)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  1  measurement request
req_ready  output  1  high only in IDLE
req_log2  input  3  log2 of run count; values >MAX_LOG2 clamp to MAX_LOG2
abort  input  1  synchronous abort; returns to IDLE, no response
meas_start  output  1  start pulse to measurement macro
meas_cnt  input  CNT_WIDTH  measured count from macro
rsp_valid  output  1  result available
rsp_ready  input  1  result consumed
rsp_avg  output  CNT_WIDTH  sum >> n (truncating)
rsp_min  output  CNT_WIDTH  min of nonzero samples; 0 if none
rsp_max  output  CNT_WIDTH  max of nonzero samples; 0 if none
rsp_zero_cnt  output  MAX_LOG2+1  number of runs that returned 0 (invalid)
busy  output  1  high in any state except IDLE

Behaviour:
- Reset: state IDLE; all outputs 0 except req_ready=1. Reset mid-operation: meas_start drops immediately, accumulators cleared, no response.
- All outputs registered or pure state decodes; rsp_* stable while rsp_valid=1.
- FSM states: IDLE, START, WAIT, SAMPLE, GAP, DONE.
- IDLE: on req_valid&req_ready latch n=clamp(req_log2), K=1<<n; clear sum (CNT_WIDTH+MAX_LOG2 bits), min=all-ones, max=0, zero_cnt=0, run_idx=0 -> START.
- START: meas_start=1 for exactly this cycle -> WAIT, timer=0. meas_start=0 in every other state.
- WAIT: timer++ each cycle; at timer==WAIT_CYCLES-1 -> SAMPLE.
- SAMPLE: capture meas_cnt; sum+=meas_cnt. If meas_cnt==0: zero_cnt++, min/max untouched; else update min/max. If run_idx==K-1 -> DONE, else run_idx++ -> GAP.
- GAP: GAP_CYCLES cycles -> START.
- DONE: rsp_valid=1; rsp_avg=sum>>n; rsp_min = (min==all-ones && no nonzero sample) ? 0 : min. Leave on rsp_valid&rsp_ready -> IDLE (rsp_valid low next cycle; req_ready high next cycle). New request accepted earliest cycle after handshake.
- Timing (accept edge = cycle 0): run r START at cycle 1+r*(WAIT_CYCLES+2+GAP_CYCLES); rsp_valid first high at cycle 1+(K-1)*(WAIT_CYCLES+2+GAP_CYCLES)+WAIT_CYCLES+2. Defaults, K=1: cycle 67; K=4: cycle 277.
- abort: any state except IDLE -> IDLE next cycle, accumulators cleared; in DONE drops response even if rsp_ready same cycle (abort wins). abort in IDLE ignored; abort and req_valid same cycle in IDLE: request accepted.
- req_valid while busy ignored (req_ready=0); no queuing.
- Sum never overflows: K*max(CNT_WIDTH) fits CNT_WIDTH+MAX_LOG2 bits.

Test Plan:
- Reset then req_log2=0, stub meas_cnt=14 -> one meas_start pulse at cycle 1; rsp_valid at cycle 67; avg=14, min=14, max=14, zero_cnt=0.
- req_log2=2, stub returns 10,12,13,15 per run -> 4 single-cycle pulses 70 cycles apart; rsp_valid at cycle 277; avg=12, min=10, max=15, zero_cnt=0.
- req_log2=2, stub returns 0,20,0,22 -> avg=10, min=20, max=22, zero_cnt=2; all zeros -> avg=0, min=0, max=0, zero_cnt=4.
- req_log2=7 -> clamped to 4: exactly 16 meas_start pulses; hold rsp_ready=0 for 10 cycles -> rsp_* stable, busy=1, req_ready=0; then handshake -> IDLE next cycle.
- abort asserted in WAIT of run 2 -> IDLE next cycle, no rsp_valid, no further meas_start; new request restarts cleanly with zeroed accumulators.
- rst_n pulsed low during START -> meas_start, rsp_valid, busy drop asynchronously; req_ready=1 after release.
